boot_loader: RTL

Bus initiator for the 16×16 `bootrom`. After a `start` pulse it optionally patches the writable ROM slot 7, reads ROM words 0..WORDS-1, and copies each one into main RAM at `RAM_BASE`+index, accumulating a 16-bit checksum. It holds the CPU in reset (`cpu_hold`) until the copy completes. It sits between `bootrom`, the RAM write port and the CPU reset input.

---
 rtl/boot_pkg.sv | 22 ++
 rtl/boot_csum.sv | 35 +++
 rtl/boot_loader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// -----------------------------------------------------------------------------
// boot_pkg -- shared definitions for the boot loader.
//   boot_state_t    : boot loader FSM states
//   ROM_DEPTH       : number of words in the boot ROM
//   ROM_PATCH_ADDR  : writable ROM slot overwritten by the patch feature
//   ROM_DW          : ROM / RAM data width
// -----------------------------------------------------------------------------
package boot_pkg;

    localparam int          ROM_DEPTH      = 16;
    localparam logic [3:0]  ROM_PATCH_ADDR = 4'h7;
    localparam int          ROM_DW         = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PATCH = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } boot_state_t;

endpackage

// File: rtl/boot_csum.sv
// -----------------------------------------------------------------------------
// boot_csum -- 16-bit wrapping accumulator for the boot copy checksum.
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (sum -> 0)
//   clr      in   synchronous clear (wins over add_en)
//   add_en   in   add add_val into the sum this cycle
//   add_val  in   value to accumulate
//   sum      out  current sum, carry discarded
// -----------------------------------------------------------------------------
module boot_csum
    import boot_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              add_en,
    input  logic [ROM_DW-1:0] add_val,
    output logic [ROM_DW-1:0] sum
);

    logic [ROM_DW-1:0] sum_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg <= '0;
        end else if (clr) begin
            sum_reg <= '0;
        end else if (add_en) begin
            sum_reg <= sum_reg + add_val;
        end
    end

    assign sum = sum_reg;

endmodule

// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader -- copies WORDS boot ROM words into RAM at RAM_BASE and holds
// the CPU in reset until the copy is complete.
//
// Optional feature: define BOOT_PATCH_EN to overwrite ROM slot 7 with
// patch_word (one PATCH cycle) before every copy.
//
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   start                 begin a copy (sampled only in IDLE or DONE)
//   patch_word            value written to ROM slot 7 (patch build only)
//   busy, done, cpu_hold  status; cpu_hold is low only in DONE
//   checksum              16-bit wrapping sum of words written to RAM
//   rom_cs/we/addr/din    ROM bus, rom_dout is the ROM read data
//   ram_cs/we/addr/wdata  RAM write port, ram_ready accepts the write
//
// All bus outputs are registered: each is loaded on the edge that enters the
// state in which it must be valid.
// -----------------------------------------------------------------------------
module boot_loader
    import boot_pkg::*;
#(
    parameter int              WORDS    = 16,
    parameter int              RAM_AW   = 8,
    parameter logic [RAM_AW-1:0] RAM_BASE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ROM_DW-1:0] patch_word,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold,
    output logic [ROM_DW-1:0] checksum,
    output logic              rom_cs,
    output logic              rom_we,
    output logic [3:0]        rom_addr,
    output logic [ROM_DW-1:0] rom_din,
    input  logic [ROM_DW-1:0] rom_dout,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [ROM_DW-1:0] ram_wdata,
    input  logic              ram_ready
);

    localparam int              IDX_W    = $clog2(ROM_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    boot_state_t       state_reg;
    logic [IDX_W-1:0]  index_reg;
    logic [ROM_DW-1:0] data_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              cpu_hold_reg;
    logic              rom_cs_reg;
    logic [3:0]        rom_addr_reg;
    logic              ram_en_reg;
    logic [RAM_AW-1:0] ram_addr_reg;
    logic [ROM_DW-1:0] ram_wdata_reg;

    logic              launch;
    logic              accept;

    // A copy is launched only from IDLE/DONE; start is a don't-care elsewhere.
    assign launch = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign accept = (state_reg == ST_WRITE) && ram_ready;

`ifdef BOOT_PATCH_EN
    logic              rom_we_reg;
    logic [ROM_DW-1:0] rom_din_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_we_reg  <= 1'b0;
            rom_din_reg <= '0;
        end else if (launch) begin
            rom_we_reg  <= 1'b1;
            rom_din_reg <= patch_word;
        end else begin
            // PATCH lasts one cycle, so the write strobe always drops next.
            rom_we_reg  <= 1'b0;
            rom_din_reg <= '0;
        end
    end

    assign rom_we  = rom_we_reg;
    assign rom_din = rom_din_reg;
`else
    logic unused_patch;
    assign unused_patch = ^patch_word;
    assign rom_we       = 1'b0;
    assign rom_din      = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            index_reg     <= '0;
            data_reg      <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            cpu_hold_reg  <= 1'b1;
            rom_cs_reg    <= 1'b0;
            rom_addr_reg  <= '0;
            ram_en_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        index_reg    <= '0;
                        busy_reg     <= 1'b1;
                        done_reg     <= 1'b0;
                        cpu_hold_reg <= 1'b1;
                        rom_cs_reg   <= 1'b1;
`ifdef BOOT_PATCH_EN
                        state_reg    <= ST_PATCH;
                        rom_addr_reg <= ROM_PATCH_ADDR;
`else
                        state_reg    <= ST_READ;
                        rom_addr_reg <= '0;
`endif
                    end
                end
                ST_PATCH: begin
                    state_reg    <= ST_READ;
                    rom_cs_reg   <= 1'b1;
                    rom_addr_reg <= '0;
                end
                ST_READ: begin
                    // ROM data is captured both for the checksum and as the
                    // registered RAM write data for the WRITE state.
                    state_reg     <= ST_WRITE;
                    data_reg      <= rom_dout;
                    rom_cs_reg    <= 1'b0;
                    rom_addr_reg  <= '0;
                    ram_en_reg    <= 1'b1;
                    ram_addr_reg  <= RAM_BASE + RAM_AW'(index_reg);
                    ram_wdata_reg <= rom_dout;
                end
                ST_WRITE: begin
                    if (ram_ready) begin
                        ram_en_reg    <= 1'b0;
                        ram_addr_reg  <= '0;
                        ram_wdata_reg <= '0;
                        if (index_reg == LAST_IDX) begin
                            state_reg    <= ST_DONE;
                            busy_reg     <= 1'b0;
                            done_reg     <= 1'b1;
                            cpu_hold_reg <= 1'b0;
                        end else begin
                            state_reg    <= ST_READ;
                            index_reg    <= index_reg + 1'b1;
                            rom_cs_reg   <= 1'b1;
                            rom_addr_reg <= 4'(index_reg + 1'b1);
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    boot_csum u_csum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (launch),
        .add_en  (accept),
        .add_val (data_reg),
        .sum     (checksum)
    );

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign cpu_hold  = cpu_hold_reg;
    assign rom_cs    = rom_cs_reg;
    assign rom_addr  = rom_addr_reg;
    assign ram_cs    = ram_en_reg;
    assign ram_we    = ram_en_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_wdata = ram_wdata_reg;

endmodule
